// File: rtl/qr_matmul_seq_if.sv
// Host-side bus of the sequenced 4x4 Q32.32 matrix multiplier: operand loading,
// run control and combinational result readback.
interface qr_matmul_seq_if #(
  parameter int DW = 64
);
  logic          wr_en;
  logic          wr_sel;
  logic [3:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic          busy;
  logic          done;
  logic [3:0]    rd_addr;
  logic [DW-1:0] rd_data;

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start, rd_addr,
    input  busy, done, rd_data
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start, rd_addr,
    output busy, done, rd_data
  );
endinterface

// File: rtl/qr_matmul_seq.sv
// Sequenced 4x4 signed Q32.32 matrix multiplier Z = X*Y: one 64x64 multiplier and
// a 128-bit accumulator walk all 64 products in row-major (i,j), inner k order.
module qr_matmul_seq #(
  parameter int DW   = 64,
  parameter int FRAC = 32,
  parameter int N    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  qr_matmul_seq_if.slave    bus
);

  localparam int NN = N * N;
  localparam int AW = 2 * DW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DW-1:0] r_x [NN];
  logic [DW-1:0] r_y [NN];
  logic [DW-1:0] r_z [NN];

  logic signed [AW-1:0] r_acc;
  // {i, j, k}: i and j select the Z element, k walks the dot product
  logic [5:0]           r_cnt;

  logic [1:0] w_i, w_j, w_k;
  logic       w_busy, w_done;
  logic       w_last;

  logic signed [AW-1:0] w_xe, w_ye, w_prod, w_sum;
  logic [DW-1:0]        w_xv, w_yv;

  assign w_i    = r_cnt[5:4];
  assign w_j    = r_cnt[3:2];
  assign w_k    = r_cnt[1:0];
  assign w_last = (r_cnt == 6'd63);

  // ---------------------------------------------------------------- FSM
  // NOTE: state and all other registers use non-blocking assignments so every
  // flop samples values from before the edge; combinational blocks use blocking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_next = S_MAC;
      S_MAC:   if (w_last)    w_next = S_DONE;
      S_DONE:  w_next = bus.start ? S_MAC : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      S_MAC:   w_busy = 1'b1;
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy    = w_busy;
  assign bus.done    = w_done;
  assign bus.rd_data = r_z[bus.rd_addr];

  // ---------------------------------------------------------------- datapath
  assign w_xv   = r_x[{w_i, w_k}];
  assign w_yv   = r_y[{w_k, w_j}];
  assign w_xe   = {{DW{w_xv[DW-1]}}, w_xv};
  assign w_ye   = {{DW{w_yv[DW-1]}}, w_yv};
  // Low 128 bits of the widened product equal the exact signed 64x64 product
  assign w_prod = w_xe * w_ye;
  assign w_sum  = (w_k == 2'd0) ? w_prod : r_acc + w_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_busy) begin
      r_acc <= w_sum;
      r_cnt <= r_cnt + 6'd1;
    end else begin
      r_cnt <= '0;
    end
  end

  // NOTE: the operand and result banks are plain registers cleared by reset,
  // since rd_data must read zero after reset; a RAM macro could not do that.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < NN; a++) begin
        r_x[a] <= '0;
        r_y[a] <= '0;
        r_z[a] <= '0;
      end
    end else begin
      // Operands are frozen during a run; a write alongside an accepted start lands first
      if (bus.wr_en && !w_busy) begin
        if (bus.wr_sel) r_y[bus.wr_addr] <= bus.wr_data;
        else            r_x[bus.wr_addr] <= bus.wr_data;
      end
      if (w_busy && (w_k == 2'd3))
        r_z[{w_i, w_j}] <= w_sum[DW+FRAC-1:FRAC];
    end
  end

endmodule

// File: tb/tb_qr_matmul_seq.sv
// Self-checking bench for qr_matmul_seq: directed scenarios plus random operands,
// checked against a plain-arithmetic matrix product model.
module tb_qr_matmul_seq;

  localparam int DW = 64;

  logic clk;
  logic rst_n;

  qr_matmul_seq_if #(.DW(DW)) bus ();

  qr_matmul_seq #(.DW(DW), .FRAC(32), .N(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [DW-1:0] mx [16];
  logic signed [DW-1:0] my [16];
  logic signed [DW-1:0] mz [16];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: Z = X*Y as an exact 128-bit dot product, then the Q32.32 slice
  function automatic void model();
    logic signed [127:0] acc, px, py;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        acc = '0;
        for (int k = 0; k < 4; k++) begin
          px  = mx[4*r+k];
          py  = my[4*k+c];
          acc = acc + px * py;
        end
        mz[4*r+c] = acc[95:32];
      end
  endfunction

  task automatic write(input logic sel, input logic [3:0] addr, input logic [DW-1:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_addr = addr;
    bus.wr_data = data;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic load_all();
    for (int a = 0; a < 16; a++) write(1'b0, 4'(a), mx[a]);
    for (int a = 0; a < 16; a++) write(1'b1, 4'(a), my[a]);
    model();
  endtask

  task automatic check_z(input string tag);
    for (int a = 0; a < 16; a++) begin
      bus.rd_addr = 4'(a);
      #1;
      check($sformatf("%s Z[%0d]", tag, a), bus.rd_data, mz[a]);
    end
  endtask

  // Observes one run starting in the cycle after its accepting edge (n = 1).
  task automatic observe(input string tag, input int interfere_at, input int abort_at,
                         input bit chain);
    int bcnt, first, last, dcnt, dat, ovl;
    bit aborted;
    bcnt = 0; first = 0; last = 0; dcnt = 0; dat = 0; ovl = 0; aborted = 1'b0;
    for (int n = 1; n <= 70; n++) begin
      if (bus.busy) begin
        bcnt++;
        if (first == 0) first = n;
        last = n;
      end
      if (bus.done) begin
        dcnt++;
        if (dat == 0) dat = n;
      end
      if (bus.busy && bus.done) ovl++;
      if (n == abort_at) begin
        rst_n = 1'b0;
        #1;
        check({tag, " busy after reset"}, 64'(bus.busy), 64'd0);
        check({tag, " done after reset"}, 64'(bus.done), 64'd0);
        aborted = 1'b1;
        break;
      end
      if (n == interfere_at) begin
        bus.start   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 1'b0;
        bus.wr_addr = 4'd5;
        bus.wr_data = 64'h0000_0007_0000_0000;
      end
      if (chain && n == 65) begin
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        break;
      end
      tick();
      bus.start = 1'b0;
      bus.wr_en = 1'b0;
    end
    if (!aborted) begin
      check({tag, " busy cycles"},  64'(bcnt),  64'd64);
      check({tag, " busy first"},   64'(first), 64'd1);
      check({tag, " busy last"},    64'(last),  64'd64);
      check({tag, " done count"},   64'(dcnt),  64'd1);
      check({tag, " done cycle"},   64'(dat),   64'd65);
      check({tag, " busy&done"},    64'(ovl),   64'd0);
    end
  endtask

  task automatic run(input string tag, input int interfere_at, input int abort_at,
                     input bit chain);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    observe(tag, interfere_at, abort_at, chain);
  endtask

  task automatic set_identity_x(input logic signed [DW-1:0] diag);
    for (int a = 0; a < 16; a++) mx[a] = (a % 5 == 0) ? diag : '0;
  endtask

  task automatic set_ramp_y();
    for (int a = 0; a < 16; a++) my[a] = 64'(a) << 32;
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_sel  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.start   = 1'b0;
    bus.rd_addr = '0;
    for (int a = 0; a < 16; a++) begin
      mx[a] = '0; my[a] = '0; mz[a] = '0;
    end
    tick();
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check_z("reset");
    rst_n = 1'b1;
    tick();

    // Identity
    set_identity_x(64'sh0000_0001_0000_0000);
    set_ramp_y();
    load_all();
    run("ident", 0, 0, 1'b0);
    check_z("ident");
    for (int a = 0; a < 16; a++) begin
      bus.rd_addr = 4'(a);
      #1;
      check($sformatf("ident Z=Y[%0d]", a), bus.rd_data, 64'(a) << 32);
    end

    // Fraction
    for (int a = 0; a < 16; a++) begin
      mx[a] = '0; my[a] = '0;
    end
    mx[5] = 64'sh0000_0000_8000_0000;
    my[5] = 64'sh0000_0003_0000_0000;
    load_all();
    run("frac", 0, 0, 1'b0);
    check_z("frac");
    bus.rd_addr = 4'd5;
    #1;
    check("frac Z11 literal", bus.rd_data, 64'h0000_0001_8000_0000);

    // Sign
    set_identity_x(64'shFFFF_FFFF_0000_0000);
    for (int a = 0; a < 16; a++) my[a] = 64'sh0000_0002_0000_0000;
    load_all();
    run("sign", 0, 0, 1'b0);
    check_z("sign");
    bus.rd_addr = 4'd10;
    #1;
    check("sign Z22 literal", bus.rd_data, 64'hFFFF_FFFE_0000_0000);

    // Busy guards: start and X11 write at cycle 10 are ignored
    set_identity_x(64'sh0000_0001_0000_0000);
    set_ramp_y();
    load_all();
    run("guard", 10, 0, 1'b0);
    check_z("guard");
    run("guard restart", 0, 0, 1'b0);
    check_z("guard restart");

    // Reset mid-run clears everything
    run("abort", 0, 30, 1'b0);
    for (int a = 0; a < 16; a++) begin
      bus.rd_addr = 4'(a);
      #1;
      check($sformatf("abort Z[%0d]", a), bus.rd_data, 64'd0);
    end
    tick();
    rst_n = 1'b1;
    tick();
    load_all();
    run("post-abort", 0, 0, 1'b0);
    check_z("post-abort");

    // Back-to-back: second start in the done cycle, with fresh operands
    for (int a = 0; a < 16; a++) begin
      mx[a] = {$urandom, $urandom};
      my[a] = {$urandom, $urandom};
    end
    load_all();
    run("b2b first", 0, 0, 1'b1);
    observe("b2b second", 0, 0, 1'b0);
    check_z("b2b");

    // Random operands, including a write coinciding with the accepting start
    for (int t = 0; t < 3; t++) begin
      for (int a = 0; a < 16; a++) begin
        mx[a] = {$urandom, $urandom};
        my[a] = (t == 1) ? 64'($signed(32'($urandom))) : {$urandom, $urandom};
      end
      load_all();
      mx[0] = {$urandom, $urandom};
      model();
      bus.wr_en   = 1'b1;
      bus.wr_sel  = 1'b0;
      bus.wr_addr = 4'd0;
      bus.wr_data = mx[0];
      bus.start   = 1'b1;
      tick();
      bus.wr_en   = 1'b0;
      bus.start   = 1'b0;
      observe($sformatf("rand%0d", t), 0, 0, 1'b0);
      check_z($sformatf("rand%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
